// File: rtl/vol_ramp.sv
// vol_ramp: stereo volume scaler whose gain ramps toward the slider target in
// STEP increments every RAMP_DIV clocks, with a two-stage saturating pipeline.
module vol_ramp #(
  parameter int RAMP_DIV = 1024,
  parameter int STEP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] VOLUME,
  input  logic [15:0] aud_in_lft,
  input  logic [15:0] aud_in_rght,
  input  logic        aud_vld,
  output logic [15:0] aud_out_lft,
  output logic [15:0] aud_out_rght,
  output logic        aud_out_vld,
  output logic [11:0] gain,
  output logic        ramping
);
  localparam int CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  logic [11:0] tgt, gain_nxt, dn_gap;
  logic [CW-1:0] cnt;
  logic tick;
  logic [12:0] up;
  logic signed [28:0] p_l, p_r;
  logic s1_vld;
  assign tick = cnt == CW'(RAMP_DIV - 1);
  // 13-bit sum so gain+STEP cannot wrap before the clamp to tgt
  assign up = {1'b0, gain} + 13'(STEP);
  assign dn_gap = gain - tgt;
  assign ramping = gain != tgt;
  always_comb
    gain_nxt = !tick ? gain :
               gain < tgt ? (up > {1'b0, tgt} ? tgt : up[11:0]) :
               gain > tgt ? (dn_gap > 12'(STEP) ? gain - 12'(STEP) : tgt) :
               gain;
  function automatic logic [15:0] sat(input logic signed [28:0] p);
    logic signed [28:0] s;
    s = p >>> 11;
    return s > 29'sd32767 ? 16'h7fff : s < -29'sd32768 ? 16'h8000 : s[15:0];
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt          <= '0;
      cnt          <= '0;
      gain         <= '0;
      p_l          <= '0;
      p_r          <= '0;
      s1_vld       <= 1'b0;
      aud_out_lft  <= '0;
      aud_out_rght <= '0;
      aud_out_vld  <= 1'b0;
    end else begin
      tgt    <= VOLUME;
      cnt    <= tick ? '0 : cnt + 1'b1;
      gain   <= gain_nxt;
      s1_vld <= aud_vld;
      if (aud_vld) begin
        p_l <= 29'($signed(aud_in_lft)) * 29'($signed({1'b0, gain}));
        p_r <= 29'($signed(aud_in_rght)) * 29'($signed({1'b0, gain}));
      end
      aud_out_vld <= s1_vld;
      if (s1_vld) begin
        aud_out_lft  <= sat(p_l);
        aud_out_rght <= sat(p_r);
      end
    end
  end
endmodule

// File: tb/tb_vol_ramp.sv
// tb_vol_ramp: directed bench for vol_ramp with a cycle-level reference model
// (ramp arithmetic plus a queue of scheduled output samples).
module tb_vol_ramp;
  localparam int RD = 4;
  localparam int ST = 4;
  logic clk = 1'b0, rst_n = 1'b0, aud_vld = 1'b0;
  logic [11:0] VOLUME = '0;
  logic [15:0] aud_in_lft = '0, aud_in_rght = '0;
  logic [15:0] aud_out_lft, aud_out_rght;
  logic aud_out_vld, ramping;
  logic [11:0] gain;
  int checks = 0, errors = 0;
  int m_gain, m_tgt, nrs, cyc, e_l, e_r, e_vld;
  int qd[$], ql[$], qr[$];

  vol_ramp #(.RAMP_DIV(RD), .STEP(ST)) dut (
    .clk(clk), .rst_n(rst_n), .VOLUME(VOLUME),
    .aud_in_lft(aud_in_lft), .aud_in_rght(aud_in_rght), .aud_vld(aud_vld),
    .aud_out_lft(aud_out_lft), .aud_out_rght(aud_out_rght),
    .aud_out_vld(aud_out_vld), .gain(gain), .ramping(ramping)
  );

  always #5 clk = ~clk;

  function automatic int scale(int s, int g);
    int p, q;
    p = s * g;
    q = p / 2048;
    if (p < 0 && q * 2048 != p) q = q - 1;
    return q > 32767 ? 32767 : q < -32768 ? -32768 : q;
  endfunction

  task automatic check(string name, integer act, integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: gain moves toward the previously sampled VOLUME on every
  // RD-th clock after reset; each accepted sample emerges two clocks later.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_gain = 0; m_tgt = 0; nrs = 0; e_l = 0; e_r = 0; e_vld = 0;
      qd.delete(); ql.delete(); qr.delete();
    end else begin
      int g_old;
      g_old = m_gain;
      if (nrs % RD == RD - 1) begin
        if (m_gain < m_tgt) m_gain = (m_gain + ST > m_tgt) ? m_tgt : m_gain + ST;
        else if (m_gain > m_tgt) m_gain = (m_gain - ST < m_tgt) ? m_tgt : m_gain - ST;
      end
      e_vld = 0;
      if (qd.size() > 0 && qd[0] == cyc) begin
        void'(qd.pop_front());
        e_l = ql.pop_front();
        e_r = qr.pop_front();
        e_vld = 1;
      end
      if (aud_vld) begin
        qd.push_back(cyc + 1);
        ql.push_back(scale(int'($signed(aud_in_lft)), g_old));
        qr.push_back(scale(int'($signed(aud_in_rght)), g_old));
      end
      m_tgt = int'(VOLUME);
      nrs++;
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    check("gain", gain, m_gain);
    check("ramping", ramping, m_gain != m_tgt);
    check("out_vld", aud_out_vld, e_vld);
    check("out_lft", $signed(aud_out_lft), e_l);
    check("out_rght", $signed(aud_out_rght), e_r);
  end

  task automatic wait_gain(int t, int budget);
    int n = 0;
    while (gain !== 12'(t) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("settle_gain", gain, t);
    @(negedge clk);
    check("settle_ramping", ramping, 0);
  endtask

  task automatic send(int l, int r, int xl, int xr);
    int n = 0;
    @(negedge clk);
    aud_vld = 1'b1;
    aud_in_lft = 16'(l);
    aud_in_rght = 16'(r);
    do begin
      @(negedge clk);
      aud_vld = 1'b0;
      n++;
    end while (aud_out_vld !== 1'b1 && n < 5);
    check("latency", n, 2);
    check("lit_lft", $signed(aud_out_lft), xl);
    check("lit_rght", $signed(aud_out_rght), xr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, pulses;
    VOLUME = 12'd2048;
    repeat (3) @(negedge clk);
    check("rst_gain", gain, 0);
    check("rst_ramping", ramping, 0);
    check("rst_out_vld", aud_out_vld, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ramp_start", ramping, 1);
    repeat (3) @(negedge clk);
    check("first_step", gain, 4);
    wait_gain(2048, 3000);
    send(1000, -1000, 1000, -1000);
    VOLUME = 12'd100;
    repeat (200) @(negedge clk);
    VOLUME = 12'd2046;
    mx = 0;
    for (int i = 0; i < 3000 && gain !== 12'd2046; i++) begin
      @(negedge clk);
      if (int'(gain) > mx) mx = int'(gain);
    end
    repeat (20) @(negedge clk) if (int'(gain) > mx) mx = int'(gain);
    check("rev_max", mx, 2046);
    check("rev_final", gain, 2046);
    VOLUME = 12'd1024;
    wait_gain(1024, 3000);
    send(-1000, 3, -500, 1);
    VOLUME = 12'd4095;
    wait_gain(4095, 5000);
    send(32767, -32768, 32767, -32768);
    VOLUME = 12'd0;
    pulses = 0;
    fork
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        aud_vld = 1'b1;
        aud_in_lft = 16'(1000 * (i + 1));
        aud_in_rght = 16'(-3000 + 777 * i);
      end
      repeat (14) begin
        @(negedge clk);
        if (aud_out_vld === 1'b1) pulses++;
      end
    join_any
    @(negedge clk);
    aud_vld = 1'b0;
    wait fork;
    check("stream_pulses", pulses, 8);
    @(negedge clk);
    aud_vld = 1'b1;
    aud_in_lft = 16'(12345);
    @(negedge clk);
    aud_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_gain", gain, 0);
    check("async_vld", aud_out_vld, 0);
    check("async_lft", aud_out_lft, 0);
    check("async_rght", aud_out_rght, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (aud_out_vld === 1'b1) pulses++;
    end
    check("post_rst_pulses", pulses, 0);
    check("post_rst_ramping", ramping, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
